stack: RTL and testbench
========================

# stack

Parameterised synchronous LIFO (last-in, first-out) buffer holding up to DEPTH words of WIDTH bits. It serves as a general-purpose hardware stack in the microprocessor datapath, for example for return addresses or operand storage. The block has single-cycle push and pop, a registered read port, and combinational full/empty status.

## Interface
Parameters:
- WIDTH, default 8: data word width in bits.
- DEPTH, default 16: number of entries. Must be ≥ 2; any integer is allowed, not only powers of two.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; one clock, synchronous, active-high.
- push  input  1  write data_in onto the top of the stack this cycle.
- pop  input  1  remove the top entry and present it on data_out.
- data_in  input  WIDTH  word to push.
- data_out  output  WIDTH  registered; last popped word.
- empty  output  1  high when the stack holds 0 entries.
- full  output  1  high when the stack holds DEPTH entries.

## Operation
- State:
  - Storage array mem[0..DEPTH-1].
  - Occupancy counter count, range 0..DEPTH, width $clog2(DEPTH+1).
  - Output register data_out.
- The top entry is mem[count-1]. A push writes mem[count].
- empty = (count == 0) and full = (count == DEPTH). Both are decoded combinationally from the registered count.
- Push only (push=1, pop=0):
  - If not full: mem[count] <= data_in, count <= count+1.
  - If full: ignored. No write, count unchanged, data_out unchanged.
- Pop only (pop=1, push=0):
  - If not empty: data_out <= mem[count-1], count <= count-1.
  - If empty: ignored. data_out holds its previous value, count stays 0.
- Push and pop together:
  - If not empty (including full): data_out <= mem[count-1], mem[count-1] <= data_in, count unchanged. This replaces the top entry.
  - If empty: data_out <= data_in (pass-through), count stays 0, nothing stored.
- Neither asserted: all state is held.
- data_out changes only on a successful pop, a simultaneous push+pop, or reset. Otherwise it holds.
- Popped entries are not cleared in mem. Stale contents are never visible, because only a pop drives data_out.

## Timing
- Reset: when rst=1 at a rising edge, count <= 0 and data_out <= 0. Outputs after that edge are empty=1, full=0, data_out=0.
  - Memory contents are not reset and are don't-care.
  - rst overrides push and pop in the same cycle.
  - Reset during any sequence empties the stack.
- Push latency: the word is stored at the edge where push is sampled. empty falls, and full rises if count reaches DEPTH, immediately after that edge.
- Pop latency: the popped word appears on data_out immediately after the edge where pop is sampled, one cycle of latency. full falls and empty rises after that same edge.
- Flags reflect the state after the most recent edge. Callers gate push with !full and pop with !empty, but the block tolerates violations as specified above.
- There are no combinational paths from inputs to outputs.

## Test plan
Use WIDTH=8, DEPTH=4 for all scenarios.
- Reset: hold rst=1 for 2 cycles with push=1 asserted -> empty=1, full=0, data_out=0x00, nothing stored. A following pop leaves data_out=0x00.
- Fill and drain:
  - Push 0x11, 0x22, 0x33, 0x44 -> full=1 after the 4th edge.
  - Then pop 4 times -> data_out = 0x44, 0x33, 0x22, 0x11 on successive cycles. empty=1 after the last pop.
- Overflow: from full, push 0x55 -> full stays 1 and count stays 4. Subsequent pops return 0x44 first, and 0x55 never appears.
- Underflow: from empty, after the last popped value 0x11, pop -> data_out stays 0x11, empty stays 1, full=0.
- Simultaneous push and pop:
  - With stack [0x11, 0x22] (top 0x22), assert push=pop=1 with data_in=0x99 -> data_out=0x22, count stays 2, next pop returns 0x99.
  - From empty, push=pop=1 with data_in=0x7A -> data_out=0x7A, empty stays 1.
- Random: 15+ cycles of random push/pop with random data, checked against a reference model (a queue with the rules above), comparing data_out, empty and full every cycle, including mid-run reset.

Source files
------------

// File: rtl/stack.sv
// Synchronous LIFO stack: single-cycle push/pop, registered read port,
// combinational full/empty decoded from the registered occupancy count.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset (clears count and data_out)
//   push     - write data_in onto the top of the stack
//   pop      - remove the top entry and present it on data_out
//   data_in  - word to push
//   data_out - registered, last popped word
//   empty    - stack holds 0 entries
//   full     - stack holds DEPTH entries
module stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top_addr;
  logic [AW-1:0]    free_addr;

  // Status decode from the registered count only
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign data_out  = data_out_q;

  // Top entry sits at count-1; next free slot at count (only used when not full)
  assign top_addr  = AW'(count_q - CW'(1));
  assign free_addr = AW'(count_q);

  // Next-state and memory write control
  always_comb begin
    count_d    = count_q;
    data_out_d = data_out_q;
    we         = 1'b0;
    waddr      = free_addr;
    unique case ({push, pop})
      2'b10: begin
        if (!full) begin
          we      = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (!empty) begin
          data_out_d = mem_q[top_addr];
          count_d    = count_q - CW'(1);
        end
      end
      2'b11: begin
        // Replace the top entry; an empty stack passes data_in straight through
        if (!empty) begin
          data_out_d = mem_q[top_addr];
          we         = 1'b1;
          waddr      = top_addr;
        end else begin
          data_out_d = data_in;
        end
      end
      default: ;
    endcase
  end

  // Control state; reset wins over push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage array, not reset
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem_q[waddr] <= data_in;
    end
  end

endmodule

// File: tb/tb_stack.sv
// Testbench for stack (WIDTH=8, DEPTH=4): directed vector table, hand-written
// corner sequences, and a random run against a queue reference model.
module tb_stack;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;

  int checks = 0;
  int errors = 0;

  stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .data_in  (data_in),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic       exp_empty;
    logic       exp_full;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%02h expected 0x%02h", name, idx, act, exp);
    end
  endtask

  // Drive inputs (called away from the edge), clock once, sample 1ns after the edge
  task automatic step(input logic r, input logic pu, input logic po, input logic [7:0] d);
    rst = r; push = pu; pop = po; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int idx, input logic [7:0] d, input logic e, input logic f);
    chk({name, ".data_out"}, idx, data_out, d);
    chk({name, ".empty"}, idx, 8'(empty), 8'(e));
    chk({name, ".full"}, idx, 8'(full), 8'(f));
  endtask

  logic [7:0] q [$];
  logic [7:0] m_dout;

  initial begin
    rst = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;

    //          rst   push  pop   din    dout   empty full
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'hAA, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'hAA, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h33, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h44, 8'h00, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h55, 8'h00, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h44, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h33, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h22, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h11, 8'h11, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h22, 8'h11, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 8'h99, 8'h22, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h99, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 8'h7A, 8'h7A, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h7A, 1'b1, 1'b0};

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].din);
      expect_out("vec", i, vecs[i].exp_dout, vecs[i].exp_empty, vecs[i].exp_full);
    end

    // Push+pop while full replaces the top and keeps full
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'hA1);
    step(1'b0, 1'b1, 1'b0, 8'hA2);
    step(1'b0, 1'b1, 1'b0, 8'hA3);
    step(1'b0, 1'b1, 1'b0, 8'hA4);
    expect_out("fill", 0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'hB5);
    expect_out("full_swap", 0, 8'hA4, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    expect_out("full_swap", 1, 8'hB5, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    expect_out("full_swap", 2, 8'hA3, 1'b0, 1'b0);

    // Reset with pop asserted on a non-empty stack empties it and clears data_out
    step(1'b1, 1'b0, 1'b1, 8'h00);
    expect_out("rst_pop", 0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    expect_out("rst_pop", 1, 8'h00, 1'b1, 1'b0);

    // Random run against a queue model, including occasional resets
    q.delete();
    m_dout = 8'h00;
    for (int c = 0; c < 200; c++) begin
      logic r, pu, po;
      logic [7:0] d;
      r  = ($urandom_range(0, 24) == 0);
      pu = $urandom_range(0, 1) == 1;
      po = $urandom_range(0, 1) == 1;
      d  = 8'($urandom);
      if (r) begin
        q.delete();
        m_dout = 8'h00;
      end else if (pu && po) begin
        if (q.size() > 0) begin
          m_dout = q[q.size()-1];
          q[q.size()-1] = d;
        end else begin
          m_dout = d;
        end
      end else if (pu) begin
        if (q.size() < DEPTH) q.push_back(d);
      end else if (po) begin
        if (q.size() > 0) m_dout = q.pop_back();
      end
      step(r, pu, po, d);
      expect_out("rand", c, m_dout, q.size() == 0, q.size() == DEPTH);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
